// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard receiver and decoder that maintains the 64-bit key matrix for the blink keyboard port.
// Optional frame timeout is enabled by defining PS2KBD_TIMEOUT_EN.
module ps2_kbmat #(
   parameter int FILT    = 8,
   parameter int TMO_CYC = 98304
) (
   input  logic        mck,
   input  logic        rin,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   output logic [8:0]  map_code,
   input  logic [6:0]  map_idx,
   output logic [63:0] kbmat,
   output logic        kbd_evt,
   output logic        err
);

   localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
   logic          fclk_q, fclk_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fe;
   logic          dat;

   rx_state_t     state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic          strobe_q, strobe_d;
   logic          err_q, err_d;
   logic          tmo_hit;

   logic          ext_q, ext_d, brk_q, brk_d;
   logic [2:0]    skip_q, skip_d;
   logic          lookup_q, lookup_d;
   logic [8:0]    map_code_q, map_code_d;
   logic [63:0]   kbmat_q, kbmat_d;
   logic          evt_q, evt_d;

   assign dat = dat_s_q[1];

   // The filtered clock only follows the pin after FILT agreeing samples, which rejects glitches on the slow PS/2 line.
   always_comb begin
      clk_s_d = {clk_s_q[0], ps2_clk};
      dat_s_d = {dat_s_q[0], ps2_dat};
      fclk_d  = fclk_q;
      fcnt_d  = '0;
      fe      = 1'b0;
      if (clk_s_q[1] != fclk_q) begin
         if (fcnt_q == FW'(FILT - 1)) begin
            fclk_d = ~fclk_q;
            fe     = fclk_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

`ifdef PS2KBD_TIMEOUT_EN
   logic [16:0] tmo_cnt_q, tmo_cnt_d;

   assign tmo_hit = (state_q != RX_IDLE) && !fe && (tmo_cnt_q == 17'(TMO_CYC - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q + 17'd1;
      if (state_q == RX_IDLE || fe || tmo_hit)
         tmo_cnt_d = '0;
   end

   always_ff @(posedge mck) begin
      if (rin) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end
`else
   // Without the timeout a stalled frame simply waits for more clock edges.
   assign tmo_hit = 1'b0 & (TMO_CYC == 0);
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      strobe_d  = 1'b0;
      err_d     = 1'b0;
      if (fe) begin
         case (state_q)
            RX_IDLE: begin
               if (!dat) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            RX_DATA: begin
               shift_d   = {dat, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PAR;
            end
            RX_PAR: begin
               par_ok_d = ^{shift_q, dat};
               state_d  = RX_STOP;
            end
            RX_STOP: begin
               state_d = RX_IDLE;
               if (par_ok_q && dat) strobe_d = 1'b1;
               else                 err_d    = 1'b1;
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = RX_IDLE;
         err_d   = 1'b1;
         shift_d = '0;
      end
   end

   // Prefix bytes only set flags; a real scan code starts a one-cycle lookup through the external map.
   always_comb begin
      ext_d      = ext_q;
      brk_d      = brk_q;
      skip_d     = skip_q;
      lookup_d   = 1'b0;
      map_code_d = map_code_q;
      kbmat_d    = kbmat_q;
      evt_d      = 1'b0;
      if (strobe_q) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else begin
            case (shift_q)
               8'hE1: skip_d = 3'd7;
               8'hE0: ext_d  = 1'b1;
               8'hF0: brk_d  = 1'b1;
               8'h00, 8'hFF: begin
                  kbmat_d = '0;
                  ext_d   = 1'b0;
                  brk_d   = 1'b0;
                  evt_d   = |kbmat_q;
               end
               8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
               end
               default: begin
                  map_code_d = {ext_q, shift_q};
                  lookup_d   = 1'b1;
               end
            endcase
         end
      end else if (lookup_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
         if (map_idx[6] && (kbmat_q[map_idx[5:0]] == brk_q)) begin
            kbmat_d[map_idx[5:0]] = ~brk_q;
            evt_d                 = 1'b1;
         end
      end
   end

   always_ff @(posedge mck) begin
      if (rin) begin
         clk_s_q    <= 2'b11;
         dat_s_q    <= 2'b11;
         fclk_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= RX_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_ok_q   <= 1'b0;
         strobe_q   <= 1'b0;
         err_q      <= 1'b0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         skip_q     <= '0;
         lookup_q   <= 1'b0;
         map_code_q <= '0;
         kbmat_q    <= '0;
         evt_q      <= 1'b0;
      end else begin
         clk_s_q    <= clk_s_d;
         dat_s_q    <= dat_s_d;
         fclk_q     <= fclk_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         strobe_q   <= strobe_d;
         err_q      <= err_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         skip_q     <= skip_d;
         lookup_q   <= lookup_d;
         map_code_q <= map_code_d;
         kbmat_q    <= kbmat_d;
         evt_q      <= evt_d;
      end
   end

   assign map_code = map_code_q;
   assign kbmat    = kbmat_q;
   assign kbd_evt  = evt_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ps2_kbmat.sv
// Self-checking bench for ps2_kbmat: drives PS/2 frames, models the decoder and scoreboards kbd_evt/err pulses.
module tb_ps2_kbmat;
   localparam int TB_TMO = 2000;

   logic        mck = 1'b0;
   logic        rin = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic [8:0]  map_code;
   logic [6:0]  map_idx;
   logic [63:0] kbmat;
   logic        kbd_evt;
   logic        err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          is_err;
      logic [63:0] mat;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [63:0] m_kbmat;
   logic [8:0]  m_map_code;
   bit          m_ext, m_brk;
   int          m_skip;

   always #5 mck = ~mck;

   ps2_kbmat #(.FILT(8), .TMO_CYC(TB_TMO)) dut (
      .mck(mck), .rin(rin), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .map_code(map_code), .map_idx(map_idx), .kbmat(kbmat),
      .kbd_evt(kbd_evt), .err(err)
   );

   function automatic logic [6:0] lut(input logic [8:0] code);
      case (code)
         9'h01C:  lut = 7'h42;
         9'h175:  lut = 7'h7F;
         9'h012:  lut = 7'h40;
         default: lut = 7'h00;
      endcase
   endfunction

   always_comb map_idx = lut(map_code);

   // Every kbd_evt or err pulse must match the oldest outstanding expectation.
   always @(negedge mck) begin
      if (!rin && (kbd_evt === 1'b1 || err === 1'b1)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_output: kbd_evt=%0b err=%0b kbmat=%h required no output", kbd_evt, err, kbmat);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_err) begin
               if (err !== 1'b1 || kbd_evt !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL err_pulse: err=%0b kbd_evt=%0b required err=1 kbd_evt=0", err, kbd_evt);
               end
            end else if (kbd_evt !== 1'b1 || err !== 1'b0 || kbmat !== mon_e.mat) begin
               errors++;
               $display("[TB] FAIL kbd_evt_pulse: kbd_evt=%0b err=%0b kbmat=%h required kbd_evt=1 err=0 kbmat=%h",
                        kbd_evt, err, kbmat, mon_e.mat);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge mck);
   endtask

   task automatic model_reset();
      m_kbmat    = '0;
      m_map_code = '0;
      m_ext      = 1'b0;
      m_brk      = 1'b0;
      m_skip     = 0;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [6:0] idx;
      if (m_skip > 0) begin
         m_skip--;
      end else begin
         case (b)
            8'hE1: m_skip = 7;
            8'hE0: m_ext = 1'b1;
            8'hF0: m_brk = 1'b1;
            8'h00, 8'hFF: begin
               if (m_kbmat != 64'h0) exp_q.push_back('{is_err: 1'b0, mat: 64'h0});
               m_kbmat = '0;
               m_ext   = 1'b0;
               m_brk   = 1'b0;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
            end
            default: begin
               m_map_code = {m_ext, b};
               idx = lut(m_map_code);
               if (idx[6] && (m_kbmat[idx[5:0]] != !m_brk)) begin
                  m_kbmat[idx[5:0]] = !m_brk;
                  exp_q.push_back('{is_err: 1'b0, mat: m_kbmat});
               end
               m_ext = 1'b0;
               m_brk = 1'b0;
            end
         endcase
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0,
                             input int nbits = 11, input int gap = 40);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      if (nbits == 11) begin
         if (bad_par || bad_stop) exp_q.push_back('{is_err: 1'b1, mat: 64'h0});
         else                     model_byte(b);
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = f[i];
         wait_cyc(15);
         ps2_clk = 1'b0;
         wait_cyc(30);
         ps2_clk = 1'b1;
         wait_cyc(15);
      end
      ps2_dat = 1'b1;
      wait_cyc(gap);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_cyc(1);
      wait_cyc(20);
   endtask

   task automatic test_reset();
      rin = 1'b1;
      wait_cyc(5);
      checks++;
      if (kbmat !== 64'h0) begin errors++; $display("[TB] FAIL reset_kbmat: got %h required 0", kbmat); end
      checks++;
      if (map_code !== 9'h0) begin errors++; $display("[TB] FAIL reset_map_code: got %h required 0", map_code); end
      checks++;
      if (kbd_evt !== 1'b0) begin errors++; $display("[TB] FAIL reset_kbd_evt: got %b required 0", kbd_evt); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b required 0", err); end
      model_reset();
      rin = 1'b0;
      wait_cyc(20);
   endtask

   task automatic test_make();
      send_frame(8'h1C);
      drain();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL make_events: pending %0d required 0", exp_q.size()); exp_q.delete(); end
      checks++;
      if (kbmat !== 64'h4) begin errors++; $display("[TB] FAIL make_kbmat: got %h required %h", kbmat, 64'h4); end
      checks++;
      if (map_code !== 9'h01C) begin errors++; $display("[TB] FAIL make_map_code: got %h required 01c", map_code); end
   endtask

   task automatic test_break_typematic();
      send_frame(8'hF0);
      send_frame(8'h1C);
      drain();
      checks++;
      if (kbmat !== 64'h0) begin errors++; $display("[TB] FAIL break_kbmat: got %h required 0", kbmat); end
      send_frame(8'h1C);
      send_frame(8'h1C);
      drain();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL typematic_events: pending %0d required 0", exp_q.size()); exp_q.delete(); end
      checks++;
      if (kbmat !== 64'h4) begin errors++; $display("[TB] FAIL typematic_kbmat: got %h required %h", kbmat, 64'h4); end
   endtask

   task automatic test_extended();
      send_frame(8'hE0);
      send_frame(8'h75);
      drain();
      checks++;
      if (map_code !== 9'h175) begin errors++; $display("[TB] FAIL ext_map_code: got %h required 175", map_code); end
      checks++;
      if (kbmat !== 64'h8000_0000_0000_0004) begin errors++; $display("[TB] FAIL ext_kbmat: got %h required 8000000000000004", kbmat); end
      send_frame(8'h75);
      drain();
      checks++;
      if (map_code !== 9'h075) begin errors++; $display("[TB] FAIL ext_cleared: got %h required 075", map_code); end
      checks++;
      if (exp_q.size() != 0 || kbmat !== m_kbmat) begin
         errors++; $display("[TB] FAIL ext_invalid_lookup: kbmat %h required %h pending %0d", kbmat, m_kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_frame_errors();
      send_frame(8'h1C, 1'b1, 1'b0);
      drain();
      checks++;
      if (kbmat !== 64'h8000_0000_0000_0004) begin errors++; $display("[TB] FAIL parity_kbmat: got %h required 8000000000000004", kbmat); end
      send_frame(8'h12, 1'b0, 1'b1);
      drain();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL frame_err_events: pending %0d required 0", exp_q.size()); exp_q.delete(); end
      send_frame(8'hF0);
      send_frame(8'h1C);
      drain();
      checks++;
      if (kbmat !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL after_err_kbmat: got %h required 8000000000000000", kbmat); end
   endtask

   task automatic test_overflow();
      send_frame(8'h1C);
      send_frame(8'h00);
      drain();
      checks++;
      if (kbmat !== 64'h0) begin errors++; $display("[TB] FAIL overflow_kbmat: got %h required 0", kbmat); end
      send_frame(8'h00);
      send_frame(8'hE0);
      send_frame(8'hFF);
      send_frame(8'h1C);
      drain();
      checks++;
      if (map_code !== 9'h01C) begin errors++; $display("[TB] FAIL overflow_ext_clear: got %h required 01c", map_code); end
      checks++;
      if (exp_q.size() != 0 || kbmat !== 64'h4) begin
         errors++; $display("[TB] FAIL overflow_followup: kbmat %h required 4 pending %0d", kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'hF0, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'h12};
      for (int i = 0; i < 8; i++) send_frame(seq[i]);
      drain();
      checks++;
      if (kbmat !== 64'h4 || map_code !== 9'h01C) begin
         errors++; $display("[TB] FAIL pause_swallow: kbmat %h map_code %h required 4 and 01c", kbmat, map_code);
      end
      send_frame(8'h12);
      drain();
      checks++;
      if (kbmat !== 64'h5) begin errors++; $display("[TB] FAIL after_pause_kbmat: got %h required 5", kbmat); end
   endtask

   task automatic test_ignored();
      send_frame(8'hE0);
      send_frame(8'hFA);
      send_frame(8'hAA);
      send_frame(8'h75);
      drain();
      checks++;
      if (kbmat !== 64'h8000_0000_0000_0005) begin errors++; $display("[TB] FAIL ignored_make: got %h required 8000000000000005", kbmat); end
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'hEE);
      send_frame(8'hFE);
      send_frame(8'h75);
      drain();
      checks++;
      if (kbmat !== 64'h5 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL ignored_break: kbmat %h required 5 pending %0d", kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'hF0, 1'b0, 1'b0, 11, 0);
      send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
      send_frame(8'hF0, 1'b0, 1'b0, 11, 0);
      send_frame(8'h12, 1'b0, 1'b0, 11, 0);
      drain();
      checks++;
      if (kbmat !== 64'h0 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL back_to_back: kbmat %h required 0 pending %0d", kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h1C);
      drain();
      send_frame(8'h12, 1'b0, 1'b0, 5, 10);
      rin = 1'b1;
      wait_cyc(5);
      checks++;
      if (kbmat !== 64'h0) begin errors++; $display("[TB] FAIL midframe_reset_kbmat: got %h required 0", kbmat); end
      model_reset();
      rin = 1'b0;
      wait_cyc(20);
      send_frame(8'h1C);
      drain();
      checks++;
      if (kbmat !== 64'h4 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL after_reset_frame: kbmat %h required 4 pending %0d", kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask

`ifdef PS2KBD_TIMEOUT_EN
   task automatic test_timeout();
      exp_q.push_back('{is_err: 1'b1, mat: 64'h0});
      send_frame(8'h1C, 1'b0, 1'b0, 5, 10);
      for (int i = 0; i < TB_TMO + 500 && exp_q.size() != 0; i++) wait_cyc(1);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL timeout_err: pending %0d required 0", exp_q.size()); exp_q.delete(); end
      send_frame(8'hF0);
      send_frame(8'h1C);
      drain();
      checks++;
      if (kbmat !== 64'h0 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL after_timeout_frame: kbmat %h required 0 pending %0d", kbmat, exp_q.size());
         exp_q.delete();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_make();
      test_break_typematic();
      test_extended();
      test_frame_errors();
      test_overflow();
      test_pause();
      test_ignored();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef PS2KBD_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
